// File: rtl/io_addr_decoder_if.sv
// CPU-side bus between the one-hot d_addr write port, the I/O device handshake
// and the decoder status pulses.
interface io_addr_decoder_if;
    logic [15:0] d_addr;
    logic        d_addr_write;
    logic        io_ready;
    logic [3:0]  io_addr;
    logic        io_sel;
    logic        busy;
    logic        done;
    logic        err_onehot;
    logic        err_timeout;
    logic        dropped;

    modport master (
        output d_addr, d_addr_write, io_ready,
        input  io_addr, io_sel, busy, done, err_onehot, err_timeout, dropped
    );

    modport slave (
        input  d_addr, d_addr_write, io_ready,
        output io_addr, io_sel, busy, done, err_onehot, err_timeout, dropped
    );
endinterface

// File: rtl/io_addr_decoder.sv
// One-hot d_addr word to 4-bit I/O port index with a select/ready handshake.
// Optional device timeout is built when IO_ADDR_DECODER_TIMEOUT_EN is defined.
module io_addr_decoder #(
    parameter int TIMEOUT = 16
) (
    input logic             clk,
    input logic             rst,
    io_addr_decoder_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        SELECT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] io_addr_q, io_addr_d;
    logic       done_q, done_d;
    logic       err_onehot_q, err_onehot_d;
    logic       dropped_q, dropped_d;

`ifdef IO_ADDR_DECODER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       err_timeout_q, err_timeout_d;
`endif

    // w & (w-1) clears the lowest set bit, so a zero result means at most one bit.
    function automatic logic is_onehot(input logic [15:0] w);
        return (w != 16'h0000) && ((w & (w - 16'h0001)) == 16'h0000);
    endfunction

    function automatic logic [3:0] encode(input logic [15:0] w);
        logic [3:0] k;
        k = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w[i]) k = 4'(i);
        end
        return k;
    endfunction

    always_comb begin
        state_d      = state_q;
        io_addr_d    = io_addr_q;
        done_d       = 1'b0;
        err_onehot_d = 1'b0;
        dropped_d    = 1'b0;
`ifdef IO_ADDR_DECODER_TIMEOUT_EN
        cnt_d         = cnt_q;
        err_timeout_d = 1'b0;
`endif
        if (state_q == IDLE) begin
            if (bus.d_addr_write) begin
                if (is_onehot(bus.d_addr)) begin
                    io_addr_d = encode(bus.d_addr);
                    state_d   = SELECT;
`ifdef IO_ADDR_DECODER_TIMEOUT_EN
                    cnt_d     = 8'd0;
`endif
                end else begin
                    err_onehot_d = 1'b1;
                end
            end
        end else begin
            // Writes during a transaction are discarded unchecked.
            dropped_d = bus.d_addr_write;
            if (bus.io_ready) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
`ifdef IO_ADDR_DECODER_TIMEOUT_EN
                if (cnt_q == TO_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            io_addr_q    <= 4'd0;
            done_q       <= 1'b0;
            err_onehot_q <= 1'b0;
            dropped_q    <= 1'b0;
`ifdef IO_ADDR_DECODER_TIMEOUT_EN
            cnt_q         <= 8'd0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            io_addr_q    <= io_addr_d;
            done_q       <= done_d;
            err_onehot_q <= err_onehot_d;
            dropped_q    <= dropped_d;
`ifdef IO_ADDR_DECODER_TIMEOUT_EN
            cnt_q         <= cnt_d;
            err_timeout_q <= err_timeout_d;
`endif
        end
    end

    // Guards against an out-of-range TIMEOUT override.
    always_ff @(posedge clk) begin
        if (rst) assert (TIMEOUT >= 1 && TIMEOUT <= 255);
    end

    assign bus.io_addr    = io_addr_q;
    assign bus.io_sel     = (state_q == SELECT);
    assign bus.busy       = (state_q == SELECT);
    assign bus.done       = done_q;
    assign bus.err_onehot = err_onehot_q;
    assign bus.dropped    = dropped_q;
`ifdef IO_ADDR_DECODER_TIMEOUT_EN
    assign bus.err_timeout = err_timeout_q;
`else
    assign bus.err_timeout = 1'b0;
`endif

endmodule
